// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the EX stage and the RV32M sequencer.
// The EX stage drives the request side; the sequencer answers with stall/done.
interface muldiv_sequencer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  START;
  logic [4:0]            ALU_CONTROL;
  logic [DATA_WIDTH-1:0] OPERAND_A;
  logic [DATA_WIDTH-1:0] OPERAND_B;
  logic                  FLUSH;
  logic                  STALL;
  logic                  BUSY;
  logic                  DONE;
  logic [DATA_WIDTH-1:0] RESULT;

  modport master (
    output START, ALU_CONTROL,
    output OPERAND_A, OPERAND_B, FLUSH,
    input  STALL, BUSY, DONE, RESULT
  );

  modport slave (
    input  START, ALU_CONTROL,
    input  OPERAND_A, OPERAND_B, FLUSH,
    output STALL, BUSY, DONE, RESULT
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M unit: shift-add multiplier and restoring divider.
// Holds the pipeline via STALL until the one-cycle DONE pulse.
module muldiv_sequencer #(
  parameter int DATA_WIDTH = 32
) (
  input logic CLK,
  input logic RESETN,
  muldiv_sequencer_if.slave bus
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  localparam logic [4:0] OP_MUL    = 5'b01010;
  localparam logic [4:0] OP_MULH   = 5'b01011;
  localparam logic [4:0] OP_MULHSU = 5'b01100;
  localparam logic [4:0] OP_MULHU  = 5'b01101;
  localparam logic [4:0] OP_DIV    = 5'b01110;
  localparam logic [4:0] OP_DIVU   = 5'b01111;
  localparam logic [4:0] OP_REM    = 5'b10000;
  localparam logic [4:0] OP_REMU   = 5'b10001;

  typedef enum logic [2:0] {
    S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE
  } state_t;

  state_t         state;
  logic [4:0]     op_q;
  logic [W-1:0]   a_q, b_q;
  logic           sa_q, sb_q;
  logic [W-1:0]   mag_a_q, mag_b_q;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] acc_q;
  logic [W-1:0]   quot_q, rem_q;
  logic           busy_q, done_q;
  logic [W-1:0]   result_q;

  logic           is_m, accept;
  logic           is_div, sel_quot;
  logic           sign_a_en, sign_b_en;
  logic           neg_a, neg_b;
  logic [W-1:0]   abs_a, abs_b;
  logic           div_zero, div_ovf;
  logic [W-1:0]   fast_res;
  logic [W:0]     rem_sh;
  logic           rem_ge;
  logic [W-1:0]   rem_next;
  logic [2*W-1:0] partial;
  logic [2*W-1:0] prod;
  logic [W-1:0]   quo_fix, rem_fix;
  logic [W-1:0]   result_next;

  assign is_m = (bus.ALU_CONTROL >= OP_MUL)
             && (bus.ALU_CONTROL <= OP_REMU);
  assign accept = (state == S_IDLE) && bus.START
               && is_m && !bus.FLUSH;

  assign bus.STALL  = accept | busy_q;
  assign bus.BUSY   = busy_q;
  assign bus.DONE   = done_q;
  assign bus.RESULT = result_q;

  assign is_div   = (op_q >= OP_DIV);
  assign sel_quot = (op_q == OP_DIV) || (op_q == OP_DIVU);

  assign sign_a_en = (op_q == OP_MULH) || (op_q == OP_MULHSU)
                  || (op_q == OP_DIV)  || (op_q == OP_REM);
  assign sign_b_en = (op_q == OP_MULH) || (op_q == OP_DIV)
                  || (op_q == OP_REM);

  assign neg_a = sign_a_en & a_q[W-1];
  assign neg_b = sign_b_en & b_q[W-1];
  assign abs_a = neg_a ? -a_q : a_q;
  assign abs_b = neg_b ? -b_q : b_q;

  assign div_zero = (b_q == '0);
  assign div_ovf  = ((op_q == OP_DIV) || (op_q == OP_REM))
                 && (a_q == {1'b1, {(W-1){1'b0}}})
                 && (b_q == '1);

  always_comb begin
    fast_res = '0;
    if (div_zero)
      fast_res = sel_quot ? '1 : a_q;
    else if (div_ovf)
      fast_res = sel_quot ? a_q : '0;
  end

  // One quotient bit per cycle; dividend bits enter from mag_a MSB.
  assign rem_sh   = {rem_q, mag_a_q[W-1]};
  assign rem_ge   = (rem_sh >= {1'b0, mag_b_q});
  assign rem_next = rem_ge ? W'(rem_sh - {1'b0, mag_b_q})
                           : rem_sh[W-1:0];

  assign partial = mag_b_q[cnt]
                 ? ({{W{1'b0}}, mag_a_q} << cnt) : '0;

  assign prod    = (sa_q ^ sb_q) ? -acc_q : acc_q;
  assign quo_fix = (sa_q ^ sb_q) ? -quot_q : quot_q;
  assign rem_fix = sa_q ? -rem_q : rem_q;

  always_comb begin
    result_next = prod[2*W-1:W];
    if (is_div)
      result_next = sel_quot ? quo_fix : rem_fix;
    else if (op_q == OP_MUL)
      result_next = prod[W-1:0];
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state    <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      cnt      <= '0;
      acc_q    <= '0;
      quot_q   <= '0;
      rem_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else if (bus.FLUSH) begin
      state  <= S_IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            op_q   <= bus.ALU_CONTROL;
            a_q    <= bus.OPERAND_A;
            b_q    <= bus.OPERAND_B;
            busy_q <= 1'b1;
            state  <= S_PREP;
          end
        end
        S_PREP: begin
          sa_q    <= neg_a;
          sb_q    <= neg_b;
          mag_a_q <= abs_a;
          mag_b_q <= abs_b;
          cnt     <= '0;
          acc_q   <= '0;
          quot_q  <= '0;
          rem_q   <= '0;
          if (is_div && (div_zero || div_ovf)) begin
            result_q <= fast_res;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state    <= S_DONE;
          end else begin
            state <= S_CALC;
          end
        end
        S_CALC: begin
          if (is_div) begin
            mag_a_q <= mag_a_q << 1;
            rem_q   <= rem_next;
            quot_q  <= {quot_q[W-2:0], rem_ge};
          end else begin
            acc_q <= acc_q + partial;
          end
          if (cnt == CW'(W-1))
            state <= S_FIX;
          else
            cnt <= cnt + 1'b1;
        end
        S_FIX: begin
          result_q <= result_next;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          state    <= S_DONE;
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
